// File: rtl/tester_flags_pkg.sv
// tester_flags_pkg: jump-class and condition-select encodings shared by the branch unit
package tester_flags_pkg;
   localparam logic [2:0] JF        = 3'b000;
   localparam logic [2:0] JT        = 3'b001;
   localparam logic [2:0] JMP       = 3'b010;
   localparam logic [2:0] JAL       = 3'b011;
   localparam logic [2:0] JR        = 3'b100;
   localparam logic [2:0] NOJ       = 3'b111;
   localparam logic [2:0] C_TRUE    = 3'd0;
   localparam logic [2:0] C_NEG     = 3'd1;
   localparam logic [2:0] C_ZERO    = 3'd2;
   localparam logic [2:0] C_CARRY   = 3'd4;
   localparam logic [2:0] C_NEGZERO = 3'd5;
   localparam logic [2:0] C_OVF     = 3'd7;
endpackage

// File: rtl/tester_flags_cond_eval.sv
// tf_cond_eval: selects one flag condition; unused cond codes evaluate false
import tester_flags_pkg::*;
module tf_cond_eval (
   input  logic       O,
   input  logic       S,
   input  logic       C,
   input  logic       Z,
   input  logic [2:0] cond,
   output logic       c
);
   always_comb begin
      case (cond)
         C_TRUE:    c = 1'b1;
         C_NEG:     c = S;
         C_ZERO:    c = Z;
         C_CARRY:   c = C;
         C_NEGZERO: c = S & Z;
         C_OVF:     c = O;
         default:   c = 1'b0;
      endcase
   end
endmodule

// File: rtl/tester_flags.sv
// tester_flags: active-low jump select to the PC-source mux, plus a registered copy
import tester_flags_pkg::*;
module tester_flags (
   input  logic       clk,
   input  logic       rst,
   input  logic       O,
   input  logic       S,
   input  logic       C,
   input  logic       Z,
   input  logic [2:0] cond,
   input  logic [2:0] OP_TF,
   output logic       out,
   output logic       out_q
);
   logic c;
   logic out_d;
   tf_cond_eval u_cond (.O(O), .S(S), .C(C), .Z(Z), .cond(cond), .c(c));
   // unconditional and no-jump classes never look at c, so unknown flags cannot leak through
   always_comb begin
      case (OP_TF)
         JF:           out = c;
         JT:           out = ~c;
         JMP, JAL, JR: out = 1'b0;
         NOJ:          out = 1'b1;
         default:      out = 1'b1;
      endcase
      out_d = out;
   end
   always_ff @(posedge clk) begin
      if (rst) out_q <= 1'b1;
      else     out_q <= out_d;
   end
endmodule

// File: tb/tb_tester_flags.sv
// tb_tester_flags: directed vectors feed a scoreboard queue; a monitor pops and compares
module tb_tester_flags;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic O = 1'b0, S = 1'b0, C = 1'b0, Z = 1'b0;
   logic [2:0] cond = 3'd0;
   logic [2:0] OP_TF = 3'b111;
   logic out, out_q;
   typedef struct {
      string name;
      bit    reg_sel;
      logic  exp;
   } entry_t;
   entry_t sb[$];
   event chk_ev;
   int passed = 0;
   int total = 0;
   tester_flags dut (.clk(clk), .rst(rst), .O(O), .S(S), .C(C), .Z(Z),
      .cond(cond), .OP_TF(OP_TF), .out(out), .out_q(out_q));
   always #5 clk = ~clk;
   function automatic logic cval(input logic [2:0] cd, input logic [3:0] f);
      // f = {O,S,C,Z}
      case (cd)
         3'd0: return 1'b1;
         3'd1: return f[2];
         3'd2: return f[0];
         3'd4: return f[1];
         3'd5: return f[2] & f[0];
         3'd7: return f[3];
         default: return 1'b0;
      endcase
   endfunction
   task automatic apply(input logic [2:0] op, input logic [2:0] cd, input logic [3:0] f);
      OP_TF = op;
      cond = cd;
      {O, S, C, Z} = f;
      #1;
   endtask
   task automatic chk(input string n, input bit reg_sel, input logic exp);
      sb.push_back('{n, reg_sel, exp});
      ->chk_ev;
      #1;
   endtask
   initial begin
      entry_t e;
      logic act;
      forever begin
         @(chk_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.reg_sel ? out_q : out;
            total++;
            if (act === e.exp) passed++;
            else $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
         end
      end
   end
   initial begin
      logic [2:0] conds [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd7};
      logic [2:0] ops [8] = '{3'b111, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000, 3'b001};
      logic exp;
      #2;
      foreach (ops[k]) begin
         for (int i = 0; i < 6; i++) begin
            for (int f = 0; f < 16; f++) begin
               apply(ops[k], conds[i], 4'(f));
               case (ops[k])
                  3'b010, 3'b011, 3'b100: exp = 1'b0;
                  3'b000: exp = cval(conds[i], 4'(f));
                  3'b001: exp = ~cval(conds[i], 4'(f));
                  default: exp = 1'b1;
               endcase
               chk($sformatf("sweep op=%b cond=%0d f=%b", ops[k], conds[i], 4'(f)), 1'b0, exp);
            end
         end
      end
      apply(3'b000, 3'd0, 4'b0000); chk("jf true", 0, 1'b1);
      apply(3'b000, 3'd1, 4'b0100); chk("jf neg S=1", 0, 1'b1);
      apply(3'b000, 3'd1, 4'b1011); chk("jf neg S=0", 0, 1'b0);
      apply(3'b000, 3'd5, 4'b0101); chk("jf negzero S=Z=1", 0, 1'b1);
      apply(3'b000, 3'd5, 4'b0100); chk("jf negzero S=1 Z=0", 0, 1'b0);
      apply(3'b000, 3'd7, 4'b0111); chk("jf ovf O=0", 0, 1'b0);
      apply(3'b001, 3'd0, 4'b0000); chk("jt true", 0, 1'b0);
      apply(3'b001, 3'd2, 4'b0001); chk("jt zero Z=1", 0, 1'b0);
      apply(3'b001, 3'd2, 4'b1110); chk("jt zero Z=0", 0, 1'b1);
      apply(3'b001, 3'd4, 4'b1101); chk("jt carry C=0", 0, 1'b1);
      apply(3'b101, 3'd0, 4'b1111); chk("reserved 101", 0, 1'b1);
      apply(3'b110, 3'd0, 4'b1111); chk("reserved 110", 0, 1'b1);
      apply(3'b000, 3'd3, 4'b1111); chk("jf cond3", 0, 1'b0);
      apply(3'b000, 3'd6, 4'b1111); chk("jf cond6", 0, 1'b0);
      apply(3'b001, 3'd3, 4'b1111); chk("jt cond3", 0, 1'b1);
      apply(3'b001, 3'd6, 4'b1111); chk("jt cond6", 0, 1'b1);
      OP_TF = 3'b010; cond = 3'd5; {O, S, C, Z} = 4'bxxxx; #1;
      chk("jmp with unknown flags", 0, 1'b0);
      @(negedge clk); rst = 1'b1; apply(3'b111, 3'd0, 4'b0000);
      @(posedge clk); #1; chk("out_q reset", 1, 1'b1);
      @(negedge clk); rst = 1'b0; apply(3'b010, 3'd0, 4'b0000);
      @(posedge clk); #1; chk("out_q jmp", 1, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; chk("out_q reset override", 1, 1'b1);
      chk("out unaffected by rst", 0, 1'b0);
      @(negedge clk); rst = 1'b0; apply(3'b000, 3'd1, 4'b0000);
      @(posedge clk); #1; chk("out_q jf taken", 1, 1'b0);
      @(negedge clk); apply(3'b000, 3'd1, 4'b0100);
      @(posedge clk); #1; chk("out_q jf not taken", 1, 1'b1);
      #5;
      if (sb.size() != 0) begin
         total++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
